// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, shift right/left (serial or rotate), parallel load,
// with a saturating shift counter and a one-cycle done pulse when the counter fills.
module shift_reg_universal #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0,
    parameter bit                   ROTATE    = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           en,
    input  logic [1:0]                     mode,
    input  logic                           sin_r,
    input  logic                           sin_l,
    input  logic [WIDTH-1:0]               d,
    output logic [WIDTH-1:0]               q,
    output logic                           sout_r,
    output logic                           sout_l,
    output logic [$clog2(WIDTH+1)-1:0]     cnt,
    output logic                           done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             shift_c;
    logic             in_r_c, in_l_c;

    // In rotate builds the outgoing bit replaces the serial input
    assign in_r_c = ROTATE ? q_q[0]       : sin_r;
    assign in_l_c = ROTATE ? q_q[WIDTH-1] : sin_l;

    // Next-state: clr beats enable, enable gates every mode
    always_comb begin
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        shift_c = 1'b0;
        if (clr) begin
            q_d   = RESET_VAL;
            cnt_d = '0;
        end else if (en) begin
            case (mode)
                MODE_HOLD: begin
                    q_d = q_q;
                end
                MODE_RIGHT: begin
                    q_d     = {in_r_c, q_q[WIDTH-1:1]};
                    shift_c = 1'b1;
                end
                MODE_LEFT: begin
                    q_d     = {q_q[WIDTH-2:0], in_l_c};
                    shift_c = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
            // Counter saturates; done fires only on the step into saturation
            if (shift_c && (cnt_q != CW'(WIDTH))) begin
                cnt_d  = cnt_q + CW'(1);
                done_d = (cnt_q == CW'(WIDTH - 1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q      = q_q;
    assign cnt    = cnt_q;
    assign done   = done_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Bench for shift_reg_universal: three builds (plain, rotate, RESET_VAL=0x5A) share one
// stimulus stream and are compared every cycle against an arithmetic model.
module tb_shift_reg_universal;

    logic       clk = 1'b0;
    logic       rst, clr, en, sin_r, sin_l;
    logic [1:0] mode;
    logic [7:0] d;

    logic [7:0] q0, q1, q2;
    logic [3:0] c0, c1, c2;
    logic       so_r0, so_r1, so_r2, so_l0, so_l1, so_l2;
    logic       dn0, dn1, dn2;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    shift_reg_universal #(.WIDTH(8), .RESET_VAL(8'h00), .ROTATE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
        .d(d), .q(q0), .sout_r(so_r0), .sout_l(so_l0), .cnt(c0), .done(dn0));
    shift_reg_universal #(.WIDTH(8), .RESET_VAL(8'h00), .ROTATE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
        .d(d), .q(q1), .sout_r(so_r1), .sout_l(so_l1), .cnt(c1), .done(dn1));
    shift_reg_universal #(.WIDTH(8), .RESET_VAL(8'h5A), .ROTATE(1'b0)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
        .d(d), .q(q2), .sout_r(so_r2), .sout_l(so_l2), .cnt(c2), .done(dn2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] rv [3] = '{8'h00, 8'h00, 8'h5A};
    bit         rot[3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] m_q[3];
    int         m_sh;
    bit         m_done;

    function automatic logic [7:0] nxt(input logic [7:0] cur, input logic [1:0] md, input bit r,
                                       input logic sr, input logic sl, input logic [7:0] ld);
        int v;
        int res;
        v = int'(cur);
        case (md)
            2'd1:    res = r ? (v / 2) + (v % 2) * 128       : (v / 2) + int'(sr) * 128;
            2'd2:    res = r ? ((v * 2) % 256) + (v / 128)   : ((v * 2) % 256) + int'(sl);
            2'd3:    res = int'(ld);
            default: res = v;
        endcase
        return 8'(res);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) m_q[i] <= rv[i];
            m_sh   <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (clr) begin
                for (int i = 0; i < 3; i++) m_q[i] <= rv[i];
                m_sh <= 0;
            end else if (en) begin
                for (int i = 0; i < 3; i++) m_q[i] <= nxt(m_q[i], mode, rot[i], sin_r, sin_l, d);
                if (mode == 2'd1 || mode == 2'd2) begin
                    m_sh   <= m_sh + 1;
                    m_done <= (m_sh + 1 == 8);
                end else if (mode == 2'd3) begin
                    m_sh <= 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [7:0] dq[3];
    logic [3:0] dc[3];
    logic       ddn[3], dsr[3], dsl[3];
    assign dq  = '{q0, q1, q2};
    assign dc  = '{c0, c1, c2};
    assign ddn = '{dn0, dn1, dn2};
    assign dsr = '{so_r0, so_r1, so_r2};
    assign dsl = '{so_l0, so_l1, so_l2};

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("model_q%0d", i),    32'(dq[i]),  32'(m_q[i]));
                check($sformatf("model_cnt%0d", i),  32'(dc[i]),  32'((m_sh > 8) ? 8 : m_sh));
                check($sformatf("model_done%0d", i), 32'(ddn[i]), 32'(m_done));
                check($sformatf("model_sout_r%0d", i), 32'(dsr[i]), 32'(m_q[i][0]));
                check($sformatf("model_sout_l%0d", i), 32'(dsl[i]), 32'(m_q[i][7]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic c, input logic e, input logic [1:0] m,
                         input logic sr, input logic sl, input logic [7:0] dd);
        clr = c; en = e; mode = m; sin_r = sr; sin_l = sl; d = dd;
        @(posedge clk);
        #2;
    endtask

    logic [7:0] exp_r[8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
    logic [7:0] exp_l[8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b0; mode = 2'd0; sin_r = 1'b0; sin_l = 1'b0; d = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        check("rst_q0", 32'(q0), 32'h00);
        check("rst_q2", 32'(q2), 32'h5A);
        check("rst_cnt0", 32'(c0), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Load, then asynchronous reset between edges, held through an edge with a load pending
        drive(0, 1, 2'd3, 0, 0, 8'hA5);
        check("load_a5_q", 32'(q0), 32'hA5);
        check("load_a5_cnt", 32'(c0), 32'd0);
        drive(0, 1, 2'd1, 0, 0, 8'h00);
        rst = 1'b1;
        #1;
        check("async_rst_q0", 32'(q0), 32'h00);
        check("async_rst_cnt0", 32'(c0), 32'd0);
        check("async_rst_done0", 32'(dn0), 32'd0);
        check("async_rst_q2", 32'(q2), 32'h5A);
        drive(0, 1, 2'd3, 0, 0, 8'hFF);
        check("rst_held_q0", 32'(q0), 32'h00);
        rst = 1'b0;
        drive(0, 1, 2'd3, 0, 0, 8'hA5);
        check("post_rst_load_q", 32'(q0), 32'hA5);

        // Right shift of 0x81 with zero serial input
        drive(0, 1, 2'd3, 0, 0, 8'h81);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("shr_sout_r_%0d", i), 32'(so_r0), 32'((i == 0 || i == 7) ? 1 : 0));
            drive(0, 1, 2'd1, 0, 0, 8'h00);
            check($sformatf("shr_q_%0d", i), 32'(q0), 32'(exp_r[i]));
            check($sformatf("shr_done_%0d", i), 32'(dn0), 32'((i == 7) ? 1 : 0));
        end
        check("shr_cnt_final", 32'(c0), 32'd8);

        // Rotate-left of 0x81 on the rotate build, then one shift past saturation
        drive(0, 1, 2'd3, 0, 0, 8'h81);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 2'd2, 0, 0, 8'h00);
            check($sformatf("rotl_q_%0d", i), 32'(q1), 32'(exp_l[i]));
            check($sformatf("rotl_done_%0d", i), 32'(dn1), 32'((i == 7) ? 1 : 0));
        end
        drive(0, 1, 2'd2, 0, 0, 8'h00);
        check("rotl_sat_cnt", 32'(c1), 32'd8);
        check("rotl_sat_done", 32'(dn1), 32'd0);
        check("rotl_sat_q", 32'(q1), 32'h03);

        // Enable low holds; clr beats a simultaneous load
        drive(0, 1, 2'd3, 0, 0, 8'h3C);
        repeat (3) drive(0, 0, 2'd1, 1, 1, 8'h00);
        check("en_low_q", 32'(q0), 32'h3C);
        check("en_low_cnt", 32'(c0), 32'd0);
        drive(1, 1, 2'd3, 0, 0, 8'hFF);
        check("clr_load_q0", 32'(q0), 32'h00);
        check("clr_load_q2", 32'(q2), 32'h5A);
        check("clr_load_cnt", 32'(c0), 32'd0);

        // Hold mode leaves state alone
        drive(0, 1, 2'd3, 0, 0, 8'hC3);
        repeat (2) drive(0, 1, 2'd0, 1, 1, 8'h00);
        check("hold_q", 32'(q0), 32'hC3);

        // Mixed directions: three left with 1s, five right with 0s
        drive(0, 1, 2'd3, 0, 0, 8'h0F);
        repeat (3) drive(0, 1, 2'd2, 0, 1, 8'h00);
        check("mixed_left_q", 32'(q0), 32'h7F);
        check("mixed_left_cnt", 32'(c0), 32'd3);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 2'd1, 0, 0, 8'h00);
            check($sformatf("mixed_done_%0d", i), 32'(dn0), 32'((i == 4) ? 1 : 0));
        end
        check("mixed_final_q", 32'(q0), 32'h03);
        check("mixed_final_cnt", 32'(c0), 32'd8);

        // Reset mid-sequence discards progress; no stale done pulse
        drive(0, 1, 2'd3, 0, 0, 8'hF0);
        repeat (5) drive(0, 1, 2'd1, 1, 0, 8'h00);
        check("mid_cnt5", 32'(c0), 32'd5);
        rst = 1'b1;
        #1;
        check("mid_rst_q0", 32'(q0), 32'h00);
        check("mid_rst_q2", 32'(q2), 32'h5A);
        check("mid_rst_cnt", 32'(c0), 32'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 2'd1, 1, 0, 8'h00);
            check($sformatf("mid_no_done_%0d", i), 32'(dn0), 32'd0);
        end
        check("mid_cnt3", 32'(c0), 32'd3);
        repeat (6) drive(0, 1, 2'd2, 0, 1, 8'h00);

        drive(0, 0, 2'd0, 0, 0, 8'h00);
        drive(0, 0, 2'd0, 0, 0, 8'h00);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
